// File: rtl/ddc_pkg.sv
// Shared widths, output field offsets and state encoding for the DDC accumulator.
package ddc_pkg;

  localparam int unsigned IN_RES         = 30;
  localparam int unsigned ACC_WIDTH      = 48;
  localparam int unsigned LEN_WIDTH      = 16;
  localparam int unsigned FCNT_WIDTH     = 16;
  localparam int unsigned DEF_FIFO_DEPTH = 4;

  localparam int unsigned IN_WIDTH  = 64;
  localparam int unsigned OUT_WIDTH = 128;

  // Input sample layout
  localparam int unsigned I_IN_LSB = 0;
  localparam int unsigned Q_IN_LSB = 32;

  // Output beat layout
  localparam int unsigned I_LSB    = 0;
  localparam int unsigned Q_LSB    = 48;
  localparam int unsigned FCNT_LSB = 96;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

endpackage

// File: rtl/ddc_accum_if.sv
// Generic AXI-Stream channel (tdata/tvalid/tready) with master/slave views.
interface ddc_accum_if #(
  parameter int unsigned WIDTH = 64
);

  logic [WIDTH-1:0] tdata;
  logic             tvalid;
  logic             tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);

endinterface

// File: rtl/sync_fifo_axis.sv
// Single-clock FIFO with a write strobe, a full flag and an AXIS read port.
module sync_fifo_axis #(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  output logic [WIDTH-1:0] m_tdata,
  output logic             m_tvalid,
  input  logic             m_tready
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             pop;
  logic             push;

  assign full     = (cnt == (AW+1)'(DEPTH));
  assign m_tvalid = (cnt != '0);
  assign m_tdata  = mem[rd_ptr];
  assign pop      = m_tvalid && m_tready;
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign push     = wr_en && (!full || pop);

  // Storage, pointers and occupancy; contents cleared so tdata reads 0 after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < DEPTH; k++) mem[k] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/ddc_accum.sv
// Integrates N IQ samples into 48-bit sums, tags each with a frame count and
// queues one beat per frame on a buffered AXIS master; drops frames when full.
module ddc_accum
  import ddc_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                   s_axis_aclk,
  input  logic                   rst,
  ddc_accum_if.slave             s_axis_ddc,
  ddc_accum_if.slave             s_axis_len,
  input  logic                   resync,
  ddc_accum_if.master            m_axis,
  output logic                   overflow,
  output logic [15:0]            drop_count
);

  if (ACC_WIDTH < IN_RES + LEN_WIDTH) begin : g_width_check
    $error("ACC_WIDTH too small to hold a full-length sum");
  end

  state_t state_q, state_d;
  logic   restart;

  logic [LEN_WIDTH-1:0]        pend_len_q;
  logic [LEN_WIDTH-1:0]        len_q;
  logic [LEN_WIDTH-1:0]        cnt_q;
  logic [LEN_WIDTH-1:0]        eff_len;
  logic [LEN_WIDTH-1:0]        base_cnt;
  logic signed [ACC_WIDTH-1:0] acc_i_q, acc_q_q;
  logic signed [ACC_WIDTH-1:0] smp_i, smp_q;
  logic signed [ACC_WIDTH-1:0] base_i, base_q;
  logic signed [ACC_WIDTH-1:0] sum_i, sum_q;
  logic [FCNT_WIDTH-1:0]       fcnt_q;
  logic                        frame_done;
  logic [OUT_WIDTH-1:0]        beat;
  logic                        emit_q;
  logic [OUT_WIDTH-1:0]        emit_data_q;
  logic                        fifo_full;
  logic                        pop;
  logic                        drop;
  logic                        unused_pad;

  assign s_axis_ddc.tready = 1'b1;
  assign s_axis_len.tready = 1'b1;
  assign unused_pad = ^{s_axis_ddc.tdata[IN_WIDTH-1:Q_IN_LSB+IN_RES],
                        s_axis_ddc.tdata[Q_IN_LSB-1:I_IN_LSB+IN_RES]};

  // State register.
  always_ff @(posedge s_axis_aclk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state: leave IDLE on the first sample or resync; RUN is terminal.
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE && (s_axis_ddc.tvalid || resync)) state_d = RUN;
  end

  // FSM output: start a fresh frame with the pending length this cycle.
  always_comb begin
    restart = 1'b0;
    if (state_q == IDLE || resync) restart = 1'b1;
  end

  // Sign-extend samples and form the frame base and running sums.
  // A restart replaces the partial frame before the current sample is added,
  // which also covers resync coinciding with a frame completion.
  always_comb begin
    smp_i      = {{(ACC_WIDTH-IN_RES){s_axis_ddc.tdata[I_IN_LSB+IN_RES-1]}},
                  s_axis_ddc.tdata[I_IN_LSB +: IN_RES]};
    smp_q      = {{(ACC_WIDTH-IN_RES){s_axis_ddc.tdata[Q_IN_LSB+IN_RES-1]}},
                  s_axis_ddc.tdata[Q_IN_LSB +: IN_RES]};
    eff_len    = restart ? pend_len_q : len_q;
    base_cnt   = restart ? '0 : cnt_q;
    base_i     = restart ? '0 : acc_i_q;
    base_q     = restart ? '0 : acc_q_q;
    sum_i      = base_i + smp_i;
    sum_q      = base_q + smp_q;
    frame_done = s_axis_ddc.tvalid && (base_cnt == eff_len - LEN_WIDTH'(1));
  end

  // Pack the completed frame into the output beat layout.
  always_comb begin
    beat = '0;
    beat[I_LSB    +: ACC_WIDTH]  = sum_i;
    beat[Q_LSB    +: ACC_WIDTH]  = sum_q;
    beat[FCNT_LSB +: FCNT_WIDTH] = fcnt_q;
  end

  // Pending length capture; zero is coerced to one.
  always_ff @(posedge s_axis_aclk or posedge rst) begin
    if (rst) begin
      pend_len_q <= LEN_WIDTH'(1);
    end else if (s_axis_len.tvalid) begin
      pend_len_q <= (s_axis_len.tdata == '0) ? LEN_WIDTH'(1) : s_axis_len.tdata;
    end
  end

  // Accumulators, sample counter, active length and frame counter.
  always_ff @(posedge s_axis_aclk or posedge rst) begin
    if (rst) begin
      acc_i_q <= '0;
      acc_q_q <= '0;
      cnt_q   <= '0;
      len_q   <= LEN_WIDTH'(1);
      fcnt_q  <= '0;
    end else if (s_axis_ddc.tvalid) begin
      if (frame_done) begin
        acc_i_q <= '0;
        acc_q_q <= '0;
        cnt_q   <= '0;
        len_q   <= pend_len_q;
        fcnt_q  <= fcnt_q + FCNT_WIDTH'(1);
      end else begin
        acc_i_q <= sum_i;
        acc_q_q <= sum_q;
        cnt_q   <= base_cnt + LEN_WIDTH'(1);
        len_q   <= eff_len;
      end
    end else if (resync) begin
      acc_i_q <= '0;
      acc_q_q <= '0;
      cnt_q   <= '0;
      len_q   <= pend_len_q;
    end
  end

  // Register the completed sum; it enters the FIFO on the following edge.
  always_ff @(posedge s_axis_aclk or posedge rst) begin
    if (rst) begin
      emit_q      <= 1'b0;
      emit_data_q <= '0;
    end else begin
      emit_q <= frame_done;
      if (frame_done) emit_data_q <= beat;
    end
  end

  sync_fifo_axis #(
    .WIDTH (OUT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (s_axis_aclk),
    .rst      (rst),
    .wr_en    (emit_q),
    .wr_data  (emit_data_q),
    .full     (fifo_full),
    .m_tdata  (m_axis.tdata),
    .m_tvalid (m_axis.tvalid),
    .m_tready (m_axis.tready)
  );

  assign pop  = m_axis.tvalid && m_axis.tready;
  assign drop = emit_q && fifo_full && !pop;

  // Sticky overflow flag and saturating drop counter.
  always_ff @(posedge s_axis_aclk or posedge rst) begin
    if (rst) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != '1) drop_count <= drop_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_ddc_accum.sv
// Directed, self-checking bench for ddc_accum.
module tb_ddc_accum;
  import ddc_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        resync = 1'b0;
  logic        overflow;
  logic [15:0] drop_count;

  always #5 clk = ~clk;

  ddc_accum_if #(.WIDTH(64))        s_ddc ();
  ddc_accum_if #(.WIDTH(LEN_WIDTH)) s_len ();
  ddc_accum_if #(.WIDTH(128))       m ();

  ddc_accum #(.FIFO_DEPTH(4)) dut (
    .s_axis_aclk (clk),
    .rst         (rst),
    .s_axis_ddc  (s_ddc),
    .s_axis_len  (s_len),
    .resync      (resync),
    .m_axis      (m),
    .overflow    (overflow),
    .drop_count  (drop_count)
  );

  int checks = 0;
  int errors = 0;
  logic [127:0] beats [$];

  // Capture every accepted output beat.
  always @(negedge clk) begin
    if (!rst && m.tvalid && m.tready) beats.push_back(m.tdata);
  end

  typedef struct {
    longint i;
    longint q;
    longint ei;
    longint eq;
    int     fc;
  } vec_t;

  vec_t tbl [5];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] mk(input longint i, input longint q, input int fc);
    logic [47:0] i48;
    logic [47:0] q48;
    logic [15:0] f16;
    i48 = i[47:0];
    q48 = q[47:0];
    f16 = fc[15:0];
    return {16'h0, f16, q48, i48};
  endfunction

  function automatic logic [63:0] pack(input longint i, input longint q);
    logic [29:0] i30;
    logic [29:0] q30;
    i30 = i[29:0];
    q30 = q[29:0];
    return {{2{q30[29]}}, q30, {2{i30[29]}}, i30};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input longint i, input longint q);
    s_ddc.tdata  = pack(i, q);
    s_ddc.tvalid = 1'b1;
    tick();
    s_ddc.tvalid = 1'b0;
  endtask

  task automatic set_len(input int n);
    s_len.tdata  = n[LEN_WIDTH-1:0];
    s_len.tvalid = 1'b1;
    tick();
    s_len.tvalid = 1'b0;
  endtask

  task automatic pulse_resync();
    resync = 1'b1;
    tick();
    resync = 1'b0;
  endtask

  task automatic wait_beats(input string name, input int n, input int budget);
    int c = 0;
    while (beats.size() < n && c < budget) begin
      tick();
      c++;
    end
    checks++;
    if (beats.size() < n) begin
      errors++;
      $display("FAIL %s: got %0d beats expected %0d", name, beats.size(), n);
    end
  endtask

  task automatic chk_beat(input string name, input logic [127:0] exp);
    logic [127:0] a;
    a = 'x;
    if (beats.size() > 0) a = beats.pop_front();
    chk(name, a, exp);
  endtask

  initial begin
    s_ddc.tdata  = '0;
    s_ddc.tvalid = 1'b0;
    s_len.tdata  = '0;
    s_len.tvalid = 1'b0;
    m.tready     = 1'b1;

    tbl[0] = '{-(64'sd1 <<< 29), (64'sd1 <<< 29) - 1, -(64'sd1 <<< 29), (64'sd1 <<< 29) - 1, 2};
    tbl[1] = '{1000, -500, 1000, -500, 3};
    tbl[2] = '{0, 0, 0, 0, 4};
    tbl[3] = '{-1, 1, -1, 1, 5};
    tbl[4] = '{(64'sd1 <<< 29) - 1, -(64'sd1 <<< 29), (64'sd1 <<< 29) - 1, -(64'sd1 <<< 29), 6};

    // Reset state
    #2;
    chk("rst_tvalid", 128'(m.tvalid), 128'(0));
    chk("rst_tdata", m.tdata, 128'(0));
    chk("rst_overflow", 128'(overflow), 128'(0));
    chk("rst_drops", 128'(drop_count), 128'(0));
    chk("rst_in_tready", 128'(s_ddc.tready), 128'(1));
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // N=4 continuous, with output latency
    set_len(4);
    for (int k = 1; k <= 8; k++) begin
      send(1000, -500);
      if (k == 4) chk("lat_after_last", 128'(m.tvalid), 128'(0));
      if (k == 5) chk("lat_plus_one", 128'(m.tvalid), 128'(1));
    end
    wait_beats("n4_beats", 2, 20);
    chk_beat("n4_f0", mk(4000, -2000, 0));
    chk_beat("n4_f1", mk(4000, -2000, 1));

    // N=1 table: one beat per sample, exact sign extension
    set_len(1);
    pulse_resync();
    for (int v = 0; v < 5; v++) send(tbl[v].i, tbl[v].q);
    wait_beats("n1_beats", 5, 20);
    for (int v = 0; v < 5; v++) chk_beat($sformatf("n1_vec%0d", v), mk(tbl[v].ei, tbl[v].eq, tbl[v].fc));

    // N=65535 at full-scale positive: no wrap
    begin
      longint big;
      longint s;
      big = (64'sd1 <<< 29) - 1;
      s = 64'sd65535 * big;
      set_len(65535);
      pulse_resync();
      for (int k = 0; k < 65535; k++) send(big, big);
      wait_beats("n65535_beat", 1, 20);
      chk_beat("n65535_sum", mk(s, s, 7));
    end

    // rst mid-frame with a beat held in the FIFO
    m.tready = 1'b0;
    set_len(2);
    pulse_resync();
    send(5, 5);
    send(5, 5);
    send(5, 5);
    repeat (2) tick();
    chk("pre_rst_tvalid", 128'(m.tvalid), 128'(1));
    rst = 1'b1;
    #1;
    chk("mid_rst_tvalid", 128'(m.tvalid), 128'(0));
    chk("mid_rst_tdata", m.tdata, 128'(0));
    repeat (2) tick();
    rst = 1'b0;
    m.tready = 1'b1;
    beats.delete();
    tick();

    // N=2 under backpressure: 4 queued, 2 dropped
    set_len(2);
    m.tready = 1'b0;
    for (int k = 0; k < 12; k++) send(1000, -500);
    repeat (3) tick();
    chk("bp_overflow", 128'(overflow), 128'(1));
    chk("bp_drops", 128'(drop_count), 128'(2));
    chk("bp_tvalid", 128'(m.tvalid), 128'(1));
    chk("bp_head", m.tdata, mk(2000, -1000, 0));
    repeat (3) tick();
    chk("bp_head_held", m.tdata, mk(2000, -1000, 0));
    m.tready = 1'b1;
    wait_beats("bp_drain", 4, 20);
    for (int f = 0; f < 4; f++) chk_beat($sformatf("bp_f%0d", f), mk(2000, -1000, f));
    send(1000, -500);
    send(1000, -500);
    wait_beats("bp_next", 1, 20);
    chk_beat("bp_gap_f6", mk(2000, -1000, 6));
    chk("bp_overflow_sticky", 128'(overflow), 128'(1));
    chk("bp_drops_hold", 128'(drop_count), 128'(2));

    // N=8 with resync discarding partial frames
    set_len(8);
    pulse_resync();
    for (int k = 0; k < 5; k++) send(100, 0);
    pulse_resync();
    for (int k = 0; k < 8; k++) send(1, 0);
    wait_beats("rs_beat", 1, 20);
    chk_beat("rs_partial_gone", mk(8, 0, 7));
    for (int k = 0; k < 7; k++) send(1, 0);
    resync = 1'b1;
    send(1, 0);
    resync = 1'b0;
    repeat (4) tick();
    chk("rs_on_last_no_beat", 128'(beats.size()), 128'(0));
    for (int k = 0; k < 7; k++) send(1, 0);
    wait_beats("rs_after", 1, 20);
    chk_beat("rs_sample_kept", mk(8, 0, 8));

    // Length change mid-frame applies at the next boundary
    set_len(4);
    pulse_resync();
    send(10, -10);
    send(10, -10);
    set_len(2);
    send(10, -10);
    send(10, -10);
    wait_beats("lc_first", 1, 20);
    chk_beat("lc_len4", mk(40, -40, 9));
    for (int k = 0; k < 4; k++) send(10, -10);
    wait_beats("lc_next", 2, 20);
    chk_beat("lc_len2_a", mk(20, -20, 10));
    chk_beat("lc_len2_b", mk(20, -20, 11));

    // Zero length is coerced to one
    set_len(0);
    pulse_resync();
    send(7, -7);
    wait_beats("len0", 1, 20);
    chk_beat("len0_as_1", mk(7, -7, 12));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ddc_accum.md
Name: ddc_accum

Overview:
- Downstream consumer of the oct-DDC summed IQ stream (64-bit: Q in [61:32], I in [29:0], 30-bit signed each).
- Integrates N consecutive IQ samples into 48-bit I/Q sums, tags each sum with a frame counter, and emits one output beat per frame on a buffered AXI-Stream master.
- Input side is always ready because the upstream stage ignores tready. Output backpressure is absorbed by a small FIFO; if the FIFO is full, the frame is dropped and flagged.

Parameters:
- IN_RES, 30, signed width of each input I/Q component.
- ACC_WIDTH, 48, accumulator width. Must be >= IN_RES + LEN_WIDTH, so the sum can never overflow.
- LEN_WIDTH, 16, width of the decimation-length register.
- FIFO_DEPTH, 4, output FIFO depth in beats (power of 2).

Ports:
- s_axis_aclk  in  1  sole clock.
- rst  in  1  asynchronous, active-high reset.
- s_axis_ddc_tdata  in  64  [61:32] Q, [29:0] I, signed. Bits [63:62] and [31:30] are sign padding and are ignored.
- s_axis_ddc_tvalid  in  1  input sample valid.
- s_axis_ddc_tready  out  1  tied to 1.
- s_axis_len_tdata  in  LEN_WIDTH  decimation length N.
- s_axis_len_tvalid  in  1  load strobe for N.
- resync  in  1  single-cycle pulse: discard the partial frame and restart.
- m_axis_tdata  out  128  [47:0] I sum, [95:48] Q sum, [111:96] frame count, [127:112] zero.
- m_axis_tvalid  out  1  output beat valid.
- m_axis_tready  in  1  downstream ready.
- overflow  out  1  sticky: at least one frame was dropped. Cleared only by rst.
- drop_count  out  16  number of dropped frames, saturating at 0xFFFF.

Behaviour:
- Reset values:
  - len_reg = 1; pending length = 1.
  - Sample count = 0; accumulators = 0; frame count = 0.
  - FIFO empty; m_axis_tvalid = 0; m_axis_tdata = 0.
  - overflow = 0; drop_count = 0.
  - State = IDLE.
- Length loading:
  - s_axis_len_tvalid latches a pending length.
  - A value of 0 is coerced to 1.
  - The pending length is copied into len_reg at the next frame boundary, on a resync, or on leaving IDLE.
- State machine:
  - IDLE → RUN on the first s_axis_ddc_tvalid after reset, or on resync. That first valid sample is accumulated.
  - RUN stays in RUN. There is no return to IDLE except through rst.
- Accumulation (RUN, tvalid = 1):
  - Each component is sign-extended from IN_RES to ACC_WIDTH.
  - If count < len_reg − 1: acc += sample; count++.
  - If count == len_reg − 1: emit acc + sample; acc loads 0; count = 0; frame count++ (wraps 0xFFFF → 0); pending length is applied.
  - With len_reg = 1, every valid sample produces one frame.
- tvalid = 0: no change to state or counters. Gaps do not count as samples.
- Emit timing:
  - The sum is written to the FIFO on the clock edge after the final sample is accepted.
  - m_axis_tvalid is asserted the following cycle if the FIFO was empty, giving 2-cycle latency from last sample to tvalid.
  - The frame count in a beat is its pre-increment value (the first frame is 0).
- FIFO:
  - Standard AXIS master; tdata is held stable while tvalid=1 and tready=0.
  - A push and a pop in the same cycle while full is allowed: the pop frees the slot and the push succeeds.
- Frame drop: if an emit finds the FIFO full with no simultaneous pop:
  - The frame is discarded, overflow is set to 1, and drop_count is incremented.
  - The frame count still increments, so a gap in the count marks the drop.
- resync:
  - Zeroes acc and count and applies the pending length.
  - Does not touch the frame count, FIFO, or flags.
- resync together with a valid sample: resync wins for the existing partial frame, and that same sample becomes sample 0 of the new frame.
- resync together with a frame completion: the completing frame is discarded (not emitted), and the sample starts the new frame.
- rst during operation: asynchronously returns everything to reset values. FIFO contents are lost and m_axis_tvalid drops immediately.

Decomposition:
- Shared package ddc_pkg holds:
  - IN_RES, ACC_WIDTH, LEN_WIDTH;
  - the output field offsets (I_LSB = 0, Q_LSB = 48, FCNT_LSB = 96);
  - the state enum {IDLE, RUN}.
- One sub-module: sync_fifo_axis, a parameterised width/depth FIFO with an AXIS read port, a full flag, and asynchronous rst.
- Accumulator and control logic stay in ddc_accum.

Test Plan:
- N=4, continuous samples with I=1000, Q=−500 → one beat every 4 samples: I=4000, Q=−2000 (48-bit sign-extended), frame counts 0,1,2…; first tvalid 2 cycles after the 4th sample.
- N=1, I=−(2^29), Q=2^29−1, tready=1 → one beat per sample with exact sign-extended values; count increments each cycle.
- N=65535, all samples I=Q=2^29−1 → sum = 65535·(2^29−1) exactly, with no wrap.
- N=2, tready=0 for 12 samples → 4 beats queued, 2 frames dropped, overflow=1, drop_count=2; after release the 4 beats drain with frame counts 0–3, and the next beat carries count 6.
- N=8, resync after 5 samples, then 8 samples of I=1 → the first beat has I=8 (the partial frame is discarded); resync coinciding with the 8th sample produces no beat.
- Change N from 4 to 2 mid-frame → the current frame completes with 4 samples and later frames use 2; rst mid-frame → all outputs return to reset values at once, and the frame count restarts at 0.
